// File: rtl/spi_accel_sequencer_if.sv
// spi_accel_sequencer_if: handler, host and sample-output signals of the sequencer.
// master is the sequencer side; slave is the surrounding handler/host/display side.
interface spi_accel_sequencer_if;
    logic        int1;
    logic        done;
    logic [7:0]  rdata;
    logic [23:0] cmd;
    logic        send;
    logic        hreq;
    logic [23:0] hcmd;
    logic        hack;
    logic [7:0]  hrdata;
    logic [7:0]  xdata;
    logic [7:0]  ydata;
    logic        data_valid;
    logic        cfg_done;
    logic        overrun;
    logic        err;
    modport master (
        input  int1, done, rdata, hreq, hcmd,
        output cmd, send, hack, hrdata, xdata, ydata, data_valid, cfg_done, overrun, err
    );
    modport slave (
        output int1, done, rdata, hreq, hcmd,
        input  cmd, send, hack, hrdata, xdata, ydata, data_valid, cfg_done, overrun, err
    );
endinterface

// File: rtl/spi_accel_sequencer.sv
// spi_accel_sequencer: power-up init, then arbitrates INT1 X/Y sample reads and host commands onto one SPI engine.
// Define SPISEQ_TIMEOUT_EN to abort WAIT states after TIMEOUT cycles and flag ERR.
module spi_accel_sequencer #(
    parameter int PWRUP_DLY = 10000,
    parameter int TIMEOUT   = 255
) (
    input  logic                  clk_i,
    input  logic                  arst_l_i,
    spi_accel_sequencer_if.master bus
);
    localparam int CW = $clog2(PWRUP_DLY + TIMEOUT + 1);

    typedef enum logic [3:0] {
        PWRUP, INIT_ISSUE, INIT_WAIT, IDLE, SX_ISSUE, SX_WAIT, SY_ISSUE, SY_WAIT, H_ISSUE, H_WAIT
    } state_e;

    state_e      state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]  idx_q, idx_d;
    logic        ptr_q, ptr_d, pend_q, pend_d, ovr_q, ovr_d, err_q, err_d, cfg_q, cfg_d;
    logic        dv_q, dv_d, hack_q, hack_d;
    logic [23:0] cmd_q, cmd_d;
    logic [7:0]  shadow_q, shadow_d, x_q, x_d, y_q, y_d, hrd_q, hrd_d;
    logic        is_wait, tmo, fin, h_req, s_req, s_go, clr;

    assign is_wait = state_q inside {INIT_WAIT, SX_WAIT, SY_WAIT, H_WAIT};
`ifdef SPISEQ_TIMEOUT_EN
    assign tmo = is_wait && !bus.done && cnt_q == CW'(TIMEOUT - 1);
`else
    assign tmo = 1'b0;
`endif
    assign fin   = is_wait && (bus.done || tmo);
    // hack_q masks the request the host has not yet had a chance to drop
    assign h_req = bus.hreq && cfg_q && !hack_q;
    // a strobe seen in IDLE is served directly rather than a cycle later via the flag
    assign s_req = pend_q || bus.int1;
    assign s_go  = s_req && (!h_req || !ptr_q);
    assign clr   = state_q == IDLE && s_go;

    always_comb begin
        state_d  = state_q;
        cnt_d    = (state_q == PWRUP || is_wait) ? cnt_q + CW'(1) : '0;
        idx_d    = idx_q + 2'(state_q == INIT_WAIT && fin);
        cfg_d    = cfg_q | (state_q == INIT_WAIT && fin && idx_q == 2'd2);
        pend_d   = clr ? (pend_q & bus.int1) : (pend_q | bus.int1);
        ovr_d    = ovr_q | (bus.int1 & pend_q & !clr);
        err_d    = err_q | tmo;
        ptr_d    = state_q != IDLE ? ptr_q : s_go ? 1'b1 : h_req ? 1'b0 : ptr_q;
        shadow_d = (state_q == SX_WAIT && bus.done) ? bus.rdata : shadow_q;
        dv_d     = state_q == SY_WAIT && bus.done;
        x_d      = dv_d ? shadow_q : x_q;
        y_d      = dv_d ? bus.rdata : y_q;
        hack_d   = state_q == H_WAIT && fin;
        hrd_d    = !hack_d ? hrd_q : tmo ? 8'hFF : bus.rdata;
        cmd_d    = state_q == INIT_ISSUE ? {8'h0A, idx_q == 2'd0 ? 16'h2A01 : idx_q == 2'd1 ? 16'h2C13 : 16'h2D02} :
                   state_q == SX_ISSUE   ? 24'h0B0800 :
                   state_q == SY_ISSUE   ? 24'h0B0900 :
                   state_q == H_ISSUE    ? bus.hcmd   : cmd_q;
        case (state_q)
            PWRUP:      if (cnt_q == CW'(PWRUP_DLY - 1)) state_d = INIT_ISSUE;
            INIT_ISSUE: state_d = INIT_WAIT;
            INIT_WAIT:  if (fin) state_d = idx_q == 2'd2 ? IDLE : INIT_ISSUE;
            IDLE:       state_d = s_go ? SX_ISSUE : h_req ? H_ISSUE : IDLE;
            SX_ISSUE:   state_d = SX_WAIT;
            SX_WAIT:    if (fin) state_d = tmo ? IDLE : SY_ISSUE;
            SY_ISSUE:   state_d = SY_WAIT;
            H_ISSUE:    state_d = H_WAIT;
            SY_WAIT,
            H_WAIT:     if (fin) state_d = IDLE;
            default:    state_d = PWRUP;
        endcase
    end

    always_ff @(posedge clk_i or negedge arst_l_i) begin
        if (!arst_l_i) begin
            state_q  <= PWRUP;
            cnt_q    <= '0;
            idx_q    <= '0;
            ptr_q    <= 1'b0;
            pend_q   <= 1'b0;
            ovr_q    <= 1'b0;
            err_q    <= 1'b0;
            cfg_q    <= 1'b0;
            dv_q     <= 1'b0;
            hack_q   <= 1'b0;
            cmd_q    <= '0;
            shadow_q <= '0;
            x_q      <= '0;
            y_q      <= '0;
            hrd_q    <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            ptr_q    <= ptr_d;
            pend_q   <= pend_d;
            ovr_q    <= ovr_d;
            err_q    <= err_d;
            cfg_q    <= cfg_d;
            dv_q     <= dv_d;
            hack_q   <= hack_d;
            cmd_q    <= cmd_d;
            shadow_q <= shadow_d;
            x_q      <= x_d;
            y_q      <= y_d;
            hrd_q    <= hrd_d;
        end
    end

    assign bus.cmd        = cmd_d;
    assign bus.send       = state_q inside {INIT_ISSUE, SX_ISSUE, SY_ISSUE, H_ISSUE};
    assign bus.hack       = hack_q;
    assign bus.hrdata     = hrd_q;
    assign bus.xdata      = x_q;
    assign bus.ydata      = y_q;
    assign bus.data_valid = dv_q;
    assign bus.cfg_done   = cfg_q;
    assign bus.overrun    = ovr_q;
    assign bus.err        = err_q;
endmodule
